// File: rtl/mod_reduce_32.sv
// mod_reduce_32: byte-serial trial subtraction reducing a WIDTH+1 bit sum modulo N
module mod_reduce_32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0]   mod_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   result,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int ND = WIDTH / DIGIT;
  localparam int CW = ND > 1 ? $clog2(ND) : 1;
  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;
  state_t            state_q;
  logic [WIDTH:0]    s_q;
  logic [WIDTH-1:0]  n_q;
  logic [WIDTH-1:0]  diff_q;
  logic              borrow_q;
  logic [CW-1:0]     count_q;
  logic [WIDTH-1:0]  result_q;
  logic              err_q;
  logic              valid_q;
  logic [DIGIT:0]    digit_d;
  logic              unused_sum_hi;
  assign unused_sum_hi = ^sum_in[2*WIDTH-1:WIDTH+1];
  assign in_ready  = state_q == IDLE;
  assign result    = result_q;
  assign out_err   = err_q;
  assign out_valid = valid_q;
  // current digit difference; the top bit is the outgoing borrow
  always_comb
    digit_d = {1'b0, s_q[int'(count_q)*DIGIT +: DIGIT]}
            - {1'b0, n_q[int'(count_q)*DIGIT +: DIGIT]}
            - (DIGIT+1)'(borrow_q);
  // control FSM: capture, digit-serial subtract, select, hold until accepted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else
      case (state_q)
        IDLE: if (in_valid) begin
          s_q      <= sum_in[WIDTH:0];
          n_q      <= mod_n;
          borrow_q <= 1'b0;
          count_q  <= '0;
          state_q  <= SUB;
        end
        SUB: begin
          diff_q[int'(count_q)*DIGIT +: DIGIT] <= digit_d[DIGIT-1:0];
          borrow_q <= digit_d[DIGIT];
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(ND-1)) state_q <= FIX;
        end
        FIX: begin
          result_q <= (!s_q[WIDTH] && borrow_q) ? s_q[WIDTH-1:0] : diff_q;
          err_q    <= (n_q == '0) | (s_q[WIDTH] & ~borrow_q);
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: if (out_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_mod_reduce_32.sv
// tb_mod_reduce_32: directed vectors for the modular reduction stage
module tb_mod_reduce_32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] sum_in = '0;
  logic [31:0] mod_n = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] result;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  mod_reduce_32 dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .mod_n(mod_n), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic accept(input logic [63:0] s, input logic [31:0] n);
    @(negedge clk);
    sum_in   = s;
    mod_n    = n;
    in_valid = 1'b1;
    chk("ready_before_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sum_in   = 64'hFFFF_FFFF_DEAD_BEEF;
    mod_n    = 32'h0000_0003;
    chk("ready_after_accept", {63'd0, in_ready}, 64'd0);
  endtask
  task automatic wait_result(input string tag, input logic [31:0] exp_res, input logic exp_err);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'd5);
    chk({tag, "_result"}, {32'd0, result}, {32'd0, exp_res});
    chk({tag, "_err"}, {63'd0, out_err}, {63'd0, exp_err});
  endtask
  task automatic finish_op(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask
  task automatic run(input string tag, input logic [63:0] s, input logic [31:0] n,
                     input logic [31:0] exp_res, input logic exp_err);
    accept(s, n);
    wait_result(tag, exp_res, exp_err);
    finish_op(tag);
  endtask
  initial begin
    #2;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_err", {63'd0, out_err}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run("small", 64'h0_0000_0005, 32'd7, 32'h0000_0005, 1'b0);
    run("sub_once", 64'h0_0000_000A, 32'd7, 32'h0000_0003, 1'b0);
    run("carry", 64'h1_FFFF_FFE0, 32'hFFFF_FFFB, 32'hFFFF_FFE5, 1'b0);
    run("xborrow", 64'h0_0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0);
    run("n_zero", 64'h0_0000_0009, 32'h0, 32'h0000_0009, 1'b1);
    run("too_big", 64'h1_0000_0010, 32'h0000_0008, 32'h0000_0008, 1'b1);
    run("hi_ignored", 64'hABCD_0000_0000_000A, 32'd7, 32'h0000_0003, 1'b0);
    out_ready = 1'b0;
    accept(64'h0_0000_000A, 32'd7);
    wait_result("bp", 32'h0000_0003, 1'b0);
    sum_in   = 64'h0_0000_0005;
    mod_n    = 32'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_result", {32'd0, result}, 64'd3);
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handshake_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_handshake_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_accepted", {63'd0, in_ready}, 64'd0);
    wait_result("bp_next", 32'h0000_0005, 1'b0);
    finish_op("bp_next");
    accept(64'h0_0000_000A, 32'd7);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_result", {32'd0, result}, 64'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_spurious", {63'd0, out_valid}, 64'd0);
    end
    run("after_rst", 64'h0_0000_000A, 32'd7, 32'h0000_0003, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
